// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 6-digit segment display scanner.
// Digit 0 is the hours-tens position; patterns are segment-on = 1.
package seg_scan_pkg;

    localparam int N_DIGITS = 6;
    localparam int SEG_W    = 7;
    localparam int IDX_W    = $clog2(N_DIGITS);

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    // One pattern per digit, digit 0 in the lowest slot
    typedef logic [N_DIGITS-1:0][SEG_W-1:0] frame_t;

    function automatic logic [N_DIGITS-1:0] dig_onehot(
        input logic [IDX_W-1:0] i
    );
        logic [N_DIGITS-1:0] one;
        one = {{(N_DIGITS-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Blank/show sequencer for the digit scan: dwell counter, state and
// digit index, with strobes marking each state change and frame start.
module scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DWELL_CYC = 1000,
    parameter int BLANK_CYC = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             show,
    output logic             adv,
    output logic             frame,
    output logic [IDX_W-1:0] idx
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // Current phase has run its full length this cycle
    always_comb begin
        done = 1'b0;
        unique case (state)
            ST_BLANK: done = (cnt == BLANK_LAST);
            ST_SHOW:  done = (cnt == DWELL_LAST);
            default:  done = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_BLANK;
        else        state <= state_nxt;
    end

    // Next state: alternate blank and show once each phase expires
    always_comb begin
        state_nxt = state;
        if (done) begin
            unique case (state)
                ST_BLANK: state_nxt = ST_SHOW;
                ST_SHOW:  state_nxt = ST_BLANK;
                default:  state_nxt = ST_BLANK;
            endcase
        end
    end

    // Transition strobes for the output stage
    always_comb begin
        show = done && (state == ST_BLANK);
        adv  = done && (state == ST_SHOW);
    end

    // Phase counter restarts on every state change, so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else                         cnt <= cnt + 1'b1;
    end

    // Digit index steps after each show and wraps after the last digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    idx <= '0;
        else if (adv)  idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // Frame pulse is high for the first blank cycle of digit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame <= 1'b0;
        else        frame <= adv && (idx == IDX_LAST);
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexes six segment patterns onto one shared bus with blanking,
// frame-coherent data latching and optional hours-tens zero suppression.
module seg_display_scanner
    import seg_scan_pkg::*;
#(
    parameter int               DWELL_CYC = 1000,
    parameter int               BLANK_CYC = 50,
    parameter bit               SEG_INV   = 1'b0,
    parameter bit               DIG_INV   = 1'b0,
    parameter bit               LZ_BLANK  = 1'b1,
    parameter logic [SEG_W-1:0] ZERO_PAT  = 7'h3F
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [SEG_W-1:0]    HRM,
    input  logic [SEG_W-1:0]    HRL,
    input  logic [SEG_W-1:0]    MIN_M,
    input  logic [SEG_W-1:0]    MIN_L,
    input  logic [SEG_W-1:0]    SEC_M,
    input  logic [SEG_W-1:0]    SEC_L,
    input  logic                UPD,
    output logic [SEG_W-1:0]    SEG,
    output logic [N_DIGITS-1:0] DIG,
    output logic                FRAME
);

    localparam logic [SEG_W-1:0]    SEG_MASK = {SEG_W{SEG_INV}};
    localparam logic [N_DIGITS-1:0] DIG_MASK = {N_DIGITS{DIG_INV}};

    logic             show;
    logic             adv;
    logic [IDX_W-1:0] idx;

    frame_t           live;
    frame_t           staging;
    frame_t           active;
    frame_t           active_nxt;
    logic             pend;
    logic [SEG_W-1:0] pat;

    scan_timer #(
        .DWELL_CYC (DWELL_CYC),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk   (CLK),
        .rst_n (RST),
        .show  (show),
        .adv   (adv),
        .frame (FRAME),
        .idx   (idx)
    );

    assign live = {SEC_L, SEC_M, MIN_L, MIN_M, HRL, HRM};

    // Displayed set only moves at frame start; a same-cycle update bypasses
    always_comb begin
        active_nxt = active;
        if (FRAME) begin
            if (UPD)       active_nxt = live;
            else if (pend) active_nxt = staging;
        end
    end

    // Staging keeps the newest update until the next frame start commits it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            staging <= '0;
            active  <= '0;
            pend    <= 1'b0;
        end else begin
            active <= active_nxt;
            if (UPD)        staging <= live;
            if (FRAME)      pend    <= 1'b0;
            else if (UPD)   pend    <= 1'b1;
        end
    end

    // Pattern for the digit about to light, with hours-tens zero blanked
    always_comb begin
        pat = active_nxt[idx];
        if (LZ_BLANK && (idx == '0) && (pat == ZERO_PAT)) pat = SEG_OFF;
    end

    // Pins change only when a digit lights or goes dark
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SEG <= SEG_OFF ^ SEG_MASK;
            DIG <= DIG_MASK;
        end else if (show) begin
            SEG <= pat ^ SEG_MASK;
            DIG <= dig_onehot(idx) ^ DIG_MASK;
        end else if (adv) begin
            SEG <= SEG_OFF ^ SEG_MASK;
            DIG <= DIG_MASK;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: a frame-position model checked every cycle
// on a normal and an inverted-polarity instance, plus directed literals.
module tb_seg_display_scanner;

    localparam int DW   = 4;
    localparam int BW   = 2;
    localparam int SLOT = DW + BW;
    localparam int FR   = 6 * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic upd = 1'b0;
    logic [5:0][6:0] live_v = '0;

    logic [6:0] seg_a, seg_b;
    logic [5:0] dig_a, dig_b;
    logic       frm_a, frm_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: edges since reset release, newest update, shown set
    int              k = 0;
    logic [5:0][6:0] last_v = '0;
    logic [5:0][6:0] vals = '0;

    always #5 clk = ~clk;

    seg_display_scanner #(
        .DWELL_CYC (DW),
        .BLANK_CYC (BW)
    ) dut_a (
        .CLK   (clk),
        .RST   (rst),
        .HRM   (live_v[0]),
        .HRL   (live_v[1]),
        .MIN_M (live_v[2]),
        .MIN_L (live_v[3]),
        .SEC_M (live_v[4]),
        .SEC_L (live_v[5]),
        .UPD   (upd),
        .SEG   (seg_a),
        .DIG   (dig_a),
        .FRAME (frm_a)
    );

    seg_display_scanner #(
        .DWELL_CYC (DW),
        .BLANK_CYC (BW),
        .SEG_INV   (1'b1),
        .DIG_INV   (1'b1)
    ) dut_b (
        .CLK   (clk),
        .RST   (rst),
        .HRM   (live_v[0]),
        .HRL   (live_v[1]),
        .MIN_M (live_v[2]),
        .MIN_L (live_v[3]),
        .SEC_M (live_v[4]),
        .SEC_L (live_v[5]),
        .UPD   (upd),
        .SEG   (seg_b),
        .DIG   (dig_b),
        .FRAME (frm_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Frame n (n>=1) shows the newest update sampled by its second edge
    always @(posedge clk or negedge rst) begin : model
        logic [5:0][6:0] l;
        if (!rst) begin
            k      <= 0;
            last_v <= '0;
            vals   <= '0;
        end else begin
            l = last_v;
            if (upd) l = live_v;
            last_v <= l;
            k      <= k + 1;
            if ((k + 1) > 1 && ((k + 1) % FR) == 1) vals <= l;
        end
    end

    task automatic compare();
        int         slot;
        int         d;
        logic [6:0] es;
        logic [5:0] ed;
        logic       ef;
        logic [6:0] es_n;
        logic [5:0] ed_n;
        es = '0;
        ed = '0;
        ef = 1'b0;
        if (rst) begin
            slot = k % FR;
            d    = slot / SLOT;
            ef   = (k > 0) && (slot == 0);
            if ((slot % SLOT) >= BW) begin
                ed = 6'(1) << d;
                es = vals[d];
                if (d == 0 && es == 7'h3F) es = 7'h00;
            end
        end
        es_n = ~es;
        ed_n = ~ed;
        chk("dig_a", 32'(dig_a), 32'(ed));
        chk("seg_a", 32'(seg_a), 32'(es));
        chk("frame_a", 32'(frm_a), 32'(ef));
        chk("dig_b", 32'(dig_b), 32'(ed_n));
        chk("seg_b", 32'(seg_b), 32'(es_n));
        chk("frame_b", 32'(frm_b), 32'(ef));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            compare();
        end
    end

    task automatic to_k(input int t);
        int n;
        n = 0;
        while (k != t) begin
            if (n > 2000) begin
                chk("to_k_timeout", 32'(k), 32'(t));
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse(input logic [5:0][6:0] v);
        live_v = v;
        upd    = 1'b1;
        @(negedge clk);
        upd    = 1'b0;
    endtask

    initial begin
        // Reset held with a toggling strobe
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            upd    = ~upd;
            live_v = 42'({$urandom(), $urandom()});
        end
        @(negedge clk);
        upd = 1'b0;
        chk("rst_seg", 32'(seg_a), 32'h00);
        chk("rst_dig", 32'(dig_a), 32'h00);
        chk("rst_frame", 32'(frm_a), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("first_edge_dig", 32'(dig_a), 32'h00);
        @(posedge clk);
        #1 chk("first_show_dig", 32'(dig_a), 32'h01);

        // Scan of a full set
        to_k(10);
        pulse({7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06});
        to_k(36);
        chk("frame1_pulse", 32'(frm_a), 32'h1);
        to_k(37);
        chk("frame1_low", 32'(frm_a), 32'h0);
        to_k(38);
        chk("a_d0_dig", 32'(dig_a), 32'h01);
        chk("a_d0_seg", 32'(seg_a), 32'h06);
        to_k(44);
        chk("a_d1_dig", 32'(dig_a), 32'h02);
        chk("a_d1_seg", 32'(seg_a), 32'h5B);

        // Mid-frame update must not tear
        to_k(50);
        pulse({7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F});
        to_k(62);
        chk("tear_d4_dig", 32'(dig_a), 32'h10);
        chk("tear_d4_seg", 32'(seg_a), 32'h6D);
        to_k(74);
        chk("b_d0_seg", 32'(seg_a), 32'h7F);

        // Pending set overridden by an update in the frame-start cycle
        to_k(90);
        pulse({7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20});
        to_k(108);
        chk("frame3_pulse", 32'(frm_a), 32'h1);
        pulse({7'h5B, 7'h4F, 7'h06, 7'h3F, 7'h06, 7'h5B});
        to_k(110);
        chk("byp_d0_seg", 32'(seg_a), 32'h5B);

        // Two updates in one frame: second wins
        to_k(120);
        pulse({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
        to_k(122);
        chk("byp_d2_dig", 32'(dig_a), 32'h04);
        chk("byp_d2_seg", 32'(seg_a), 32'h3F);
        to_k(130);
        pulse({7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F});

        // Leading zero suppressed, polarity-inverted instance mirrors it
        to_k(146);
        chk("lz_dig", 32'(dig_a), 32'h01);
        chk("lz_seg", 32'(seg_a), 32'h00);
        chk("inv_dig", 32'(dig_b), 32'h3E);
        chk("inv_seg", 32'(seg_b), 32'h7F);
        to_k(152);
        chk("two_d1_seg", 32'(seg_a), 32'h06);

        // Async reset in digit 3 show with an update pending
        to_k(156);
        pulse({7'h71, 7'h71, 7'h71, 7'h71, 7'h71, 7'h77});
        to_k(165);
        chk("pre_rst_dig", 32'(dig_a), 32'h08);
        #2 rst = 1'b0;
        #1;
        chk("arst_seg", 32'(seg_a), 32'h00);
        chk("arst_dig", 32'(dig_a), 32'h00);
        chk("arst_frame", 32'(frm_a), 32'h0);
        chk("arst_dig_b", 32'(dig_b), 32'h3F);
        chk("arst_seg_b", 32'(seg_b), 32'h7F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        to_k(2);
        chk("restart_dig", 32'(dig_a), 32'h01);
        to_k(38);
        chk("drop_d0_dig", 32'(dig_a), 32'h01);
        chk("drop_d0_seg", 32'(seg_a), 32'h00);
        to_k(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
